// File: rtl/mem_uart_streamer_if.sv
// mem_uart_streamer_if: RAM read port plus UART transmitter ready/start handshake.
interface mem_uart_streamer_if #(
  parameter int MEM_WORD_LENGTH = 12,
  parameter int MEM_ADDR_LENGTH = 12,
  parameter int UART_WIDTH      = 8
);
  logic [MEM_ADDR_LENGTH-1:0] mem_address;
  logic [MEM_WORD_LENGTH-1:0] dataFromMem;
  logic                       txByteReady;
  logic                       uartTxStart;
  logic [UART_WIDTH-1:0]      byteToUart;
  modport master (
    output mem_address, uartTxStart, byteToUart,
    input  dataFromMem, txByteReady
  );
  modport slave (
    input  mem_address, uartTxStart, byteToUart,
    output dataFromMem, txByteReady
  );
endinterface

// File: rtl/mem_uart_streamer.sv
// mem_uart_streamer: walks an inclusive RAM address range and sends each word LSB byte first to the UART.
module mem_uart_streamer #(
  parameter int MEM_WORD_LENGTH = 12,
  parameter int MEM_ADDR_LENGTH = 12,
  parameter int UART_WIDTH      = 8
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       txStartN,
  input  logic [MEM_ADDR_LENGTH-1:0] start_addr,
  input  logic [MEM_ADDR_LENGTH-1:0] end_addr,
  mem_uart_streamer_if.master        bus,
  output logic                       busy,
  output logic                       done
);
  localparam int NBYTES = (MEM_WORD_LENGTH + UART_WIDTH - 1) / UART_WIDTH;
  localparam int SW     = NBYTES * UART_WIDTH;
  localparam int CW     = NBYTES > 1 ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {IDLE, READ, LOAD, SEND, WAIT_LOW, WAIT_HIGH, FINISH} state_t;

  state_t                     state, next;
  logic [MEM_ADDR_LENGTH-1:0] last;
  logic [SW-1:0]              shift;
  logic [CW-1:0]              count;
  logic                       last_byte, last_word;

  assign last_byte = count == CW'(NBYTES - 1);
  assign last_word = bus.mem_address == last;

  always_ff @(posedge clk)
    if (!rstN) state <= IDLE;
    else       state <= next;

  always_comb begin
    next = state;
    case (state)
      IDLE:      next = txStartN ? IDLE : (end_addr < start_addr ? FINISH : READ);
      READ:      next = LOAD;
      LOAD:      next = SEND;
      SEND:      next = bus.txByteReady ? WAIT_LOW : SEND;
      WAIT_LOW:  next = bus.txByteReady ? WAIT_LOW : WAIT_HIGH;
      WAIT_HIGH: next = !bus.txByteReady ? WAIT_HIGH : !last_byte ? SEND : last_word ? FINISH : READ;
      FINISH:    next = IDLE;
      default:   next = IDLE;
    endcase
  end

  // mem_address is loaded on the start edge so the registered RAM output is ready for LOAD
  always_ff @(posedge clk) begin
    if (!rstN) begin
      bus.mem_address <= '0;
      bus.uartTxStart <= 1'b0;
      bus.byteToUart  <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      last            <= '0;
      shift           <= '0;
      count           <= '0;
    end else begin
      bus.uartTxStart <= 1'b0;
      done            <= 1'b0;
      case (state)
        IDLE: if (!txStartN) begin
          busy <= 1'b1;
          last <= end_addr;
          if (!(end_addr < start_addr)) bus.mem_address <= start_addr;
        end
        LOAD: begin
          shift <= SW'(bus.dataFromMem);
          count <= '0;
        end
        SEND: if (bus.txByteReady) begin
          bus.uartTxStart <= 1'b1;
          bus.byteToUart  <= shift[UART_WIDTH-1:0];
          shift           <= shift >> UART_WIDTH;
        end
        WAIT_HIGH: if (bus.txByteReady) begin
          if (!last_byte) count <= count + 1'b1;
          else if (!last_word) bus.mem_address <= bus.mem_address + 1'b1;
        end
        FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_uart_streamer.sv
// tb_mem_uart_streamer: directed and random transfers against a byte-stream reference model.
module tb_mem_uart_streamer;
  localparam int W = 12, A = 12, U = 8, NB = (W + U - 1) / U;

  logic         clk = 0, rstN = 0, txStartN = 1;
  logic [A-1:0] start_addr = '0, end_addr = '0;
  logic         busy, done;

  mem_uart_streamer_if #(.MEM_WORD_LENGTH(W), .MEM_ADDR_LENGTH(A), .UART_WIDTH(U)) bus();

  mem_uart_streamer #(.MEM_WORD_LENGTH(W), .MEM_ADDR_LENGTH(A), .UART_WIDTH(U)) dut (
    .clk(clk), .rstN(rstN), .txStartN(txStartN), .start_addr(start_addr),
    .end_addr(end_addr), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [1<<A];
  always @(posedge clk) bus.dataFromMem <= mem[bus.mem_address];

  // transmitter model: ready drops after each accepted byte and stays low tx_len cycles
  int   tx_cnt = 0, tx_len = 20;
  logic force_low = 0;
  assign bus.txByteReady = tx_cnt == 0 && !force_low;

  logic [U-1:0] got[$];
  logic [U-1:0] exp_q[$];
  int n_pulse = 0, n_done = 0, n_busy = 0, viol = 0;
  int checks = 0, errors = 0, lows = 0;

  always @(negedge clk) begin
    if (bus.uartTxStart) begin
      if (!bus.txByteReady) viol++;
      got.push_back(bus.byteToUart);
      n_pulse++;
      tx_cnt = tx_len;
    end else if (tx_cnt > 0) tx_cnt--;
    if (done) n_done++;
    if (busy) n_busy++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input int s, input int e);
    exp_q.delete();
    for (int a = s; a <= e; a++)
      for (int b = 0; b < NB; b++) exp_q.push_back(U'((int'(mem[a]) >> (U * b)) & 'hFF));
  endtask

  task automatic start_req(input int s, input int e);
    start_addr = A'(s);
    end_addr   = A'(e);
    @(negedge clk) txStartN = 0;
    @(negedge clk) txStartN = 1;
  endtask

  task automatic wait_done(input string tag);
    int k;
    lows = 0;
    for (k = 0; k < 4000; k++) begin
      if (done) break;
      if (!busy) lows++;
      @(negedge clk);
    end
    check({tag, " done_timeout"}, k < 4000, 1);
  endtask

  task automatic compare_stream(input string tag, input int base);
    check({tag, " byte_count"}, got.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got.size()) check({tag, " byte"}, got[base + i], exp_q[i]);
  endtask

  task automatic run(input string tag, input int s, input int e);
    int base, db;
    base = got.size();
    db   = n_done;
    build_exp(s, e);
    start_req(s, e);
    wait_done(tag);
    repeat (3) @(negedge clk);
    compare_stream(tag, base);
    check({tag, " done_once"}, n_done - db, 1);
  endtask

  initial begin
    int base, pb, db, bb, unstable, np, k;
    logic [A-1:0] ma;
    logic [U-1:0] bt;
    for (int a = 0; a < (1 << A); a++) mem[a] = W'($urandom);
    repeat (3) @(negedge clk);
    check("rst mem_address", bus.mem_address, 0);
    check("rst uartTxStart", bus.uartTxStart, 0);
    check("rst byteToUart", bus.byteToUart, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    rstN = 1;
    repeat (2) @(negedge clk);

    // single word with start latency
    mem[5] = 12'hABC;
    tx_len = 20;
    base = got.size(); pb = n_pulse; db = n_done;
    build_exp(5, 5);
    start_req(5, 5);
    @(negedge clk);
    check("lat busy", busy, 1);
    check("lat mem_address", bus.mem_address, 5);
    @(negedge clk);
    check("lat no_early_pulse", bus.uartTxStart, 0);
    @(negedge clk);
    check("lat first_pulse", bus.uartTxStart, 1);
    check("lat first_byte", bus.byteToUart, 8'hBC);
    @(negedge clk);
    check("pulse one_cycle", bus.uartTxStart, 0);
    wait_done("single");
    check("single busy_at_done", busy, 0);
    repeat (3) @(negedge clk);
    compare_stream("single", base);
    check("single pulses", n_pulse - pb, 2);
    check("single done_once", n_done - db, 1);
    check("single mem_address", bus.mem_address, 5);

    // range 5..8
    mem[5] = 12'h001; mem[6] = 12'h123; mem[7] = 12'hFFF; mem[8] = 12'h800;
    tx_len = 3;
    run("range", 5, 8);
    check("range busy_throughout", lows, 0);

    // empty range
    pb = n_pulse; db = n_done; bb = n_busy;
    start_req(9, 4);
    @(negedge clk);
    check("empty done_timing", done, 1);
    check("empty busy_low", busy, 0);
    repeat (5) @(negedge clk);
    check("empty pulses", n_pulse - pb, 0);
    check("empty done_once", n_done - db, 1);
    check("empty busy_cycles", n_busy - bb, 1);

    // backpressure with ignored start requests
    force_low = 1;
    base = got.size(); pb = n_pulse;
    build_exp(5, 6);
    start_req(5, 6);
    start_addr = '0; end_addr = '0;
    unstable = 0; ma = '0; bt = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      txStartN = (i % 17 == 3) ? 1'b0 : 1'b1;
      if (i == 5) begin ma = bus.mem_address; bt = bus.byteToUart; end
      if (i > 5 && (bus.mem_address !== ma || bus.byteToUart !== bt || !busy)) unstable++;
    end
    txStartN = 1;
    check("bp stable", unstable, 0);
    check("bp mem_address", bus.mem_address, 5);
    check("bp no_pulse", n_pulse - pb, 0);
    db = n_done;
    force_low = 0;
    wait_done("bp");
    repeat (3) @(negedge clk);
    compare_stream("bp", base);
    check("bp done_once", n_done - db, 1);

    // top of address space
    mem[4095] = 12'h5A5;
    run("top", 4095, 4095);
    check("top no_wrap", bus.mem_address, 4095);

    // reset during WAIT_LOW of the second word's first byte
    tx_len = 10;
    start_req(5, 8);
    np = 0;
    for (k = 0; k < 2000 && np < 3; k++) begin
      @(negedge clk);
      if (bus.uartTxStart) np++;
    end
    check("rstmid reached", np, 3);
    rstN = 0;
    @(negedge clk);
    check("rstmid mem_address", bus.mem_address, 0);
    check("rstmid uartTxStart", bus.uartTxStart, 0);
    check("rstmid byteToUart", bus.byteToUart, 0);
    check("rstmid busy", busy, 0);
    check("rstmid done", done, 0);
    rstN = 1;
    pb = n_pulse;
    repeat (40) @(negedge clk);
    check("rstmid no_pulse", n_pulse - pb, 0);
    run("restart", 5, 8);

    // randomized ranges
    for (int it = 0; it < 8; it++) begin
      int s, e;
      s = $urandom_range(1, 4090);
      e = (it == 3) ? s - 1 : s + $urandom_range(0, 4);
      tx_len = $urandom_range(1, 12);
      for (int a = s; a <= e; a++) mem[a] = W'($urandom);
      run("random", s, e);
    end

    check("protocol", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
